// File: rtl/serial_compare_scheduler.sv
// serial_compare_scheduler: round-robin shares one MSB-first serial magnitude comparator between two requesters
module serial_compare_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_less,
  output logic             res_eq,
  output logic             res_greater
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;
  typedef enum logic [1:0] {EQ, LT, GT} cmp_t;
  state_t state;
  cmp_t cmp, cmp_nxt;
  logic ptr, grant0, grant1;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0] cnt;
  // readys are gated by rst so they drop the instant reset asserts
  always_comb begin
    grant0 = rst && state == IDLE && req0_valid && (!ptr || !req1_valid);
    grant1 = rst && state == IDLE && req1_valid && (ptr || !req0_valid);
    cmp_nxt = cmp != EQ ? cmp :
              (sh_a[WIDTH-1] && !sh_b[WIDTH-1]) ? GT :
              (!sh_a[WIDTH-1] && sh_b[WIDTH-1]) ? LT : EQ;
  end
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cmp         <= EQ;
      ptr         <= 1'b0;
      sh_a        <= '0;
      sh_b        <= '0;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_less    <= 1'b0;
      res_eq      <= 1'b0;
      res_greater <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant0 || grant1) begin
          sh_a   <= grant0 ? req0_a : req1_a;
          sh_b   <= grant0 ? req0_b : req1_b;
          res_id <= grant1;
          cnt    <= CW'(WIDTH - 1);
          cmp    <= EQ;
          state  <= SHIFT;
        end
        SHIFT: begin
          cmp  <= cmp_nxt;
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
          if (cnt == '0) begin
            res_less    <= cmp_nxt == LT;
            res_eq      <= cmp_nxt == EQ;
            res_greater <= cmp_nxt == GT;
            res_valid   <= 1'b1;
            state       <= RESULT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESULT: if (res_ready) begin
          res_valid   <= 1'b0;
          res_less    <= 1'b0;
          res_eq      <= 1'b0;
          res_greater <= 1'b0;
          ptr         <= ~res_id;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_compare_scheduler.sv
// tb_serial_compare_scheduler: directed and random checks against a transaction-level reference model
module tb_serial_compare_scheduler;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, res_valid, res_id, res_less, res_eq, res_greater;
  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 1'b1;
  int m_sh = 0;
  bit m_res = 0, m_id = 0, m_ptr = 0;
  logic [2:0] m_flags = '0;

  serial_compare_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ref_cmp(logic [W-1:0] a, logic [W-1:0] b);
    return a < b ? 3'b100 : a == b ? 3'b010 : 3'b001;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a transaction takes W compare cycles, then waits in a result slot for the consumer
  always @(negedge clk) if (chk_en) begin
    bit idle, g0, g1;
    if (!rst) begin
      m_sh = 0; m_res = 0; m_id = 0; m_ptr = 0; m_flags = '0;
    end
    idle = rst && m_sh == 0 && !m_res;
    g0 = idle && req0_valid && (!m_ptr || !req1_valid);
    g1 = idle && req1_valid && (m_ptr || !req0_valid);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("res_valid", res_valid, m_res);
    chk("res_flags", {res_less, res_eq, res_greater}, m_res ? m_flags : 3'b000);
    if (m_res) chk("res_id", res_id, m_id);
    if (rst) begin
      if (g0) begin m_sh = W; m_id = 0; m_flags = ref_cmp(req0_a, req0_b); end
      else if (g1) begin m_sh = W; m_id = 1; m_flags = ref_cmp(req1_a, req1_b); end
      else if (m_sh > 0) begin m_sh--; if (m_sh == 0) m_res = 1; end
      else if (m_res && res_ready) begin m_res = 0; m_ptr = !m_id; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit r, input logic [W-1:0] a, input logic [W-1:0] b, output int t_acc);
    bit got = 0;
    if (r) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = r ? req1_ready : req0_ready;
      if (got) chk("grant_other_idle", r ? req0_ready : req1_ready, 0);
      @(posedge clk); #1;
    end
    t_acc = cyc;
    if (!got) chk("accept_timeout", 0, 1);
    if (r) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_res(output int t);
    bit got = 0;
    t = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; t = cyc; end
    end
    if (!got) chk("result_timeout", 0, 1);
  endtask

  task automatic consume();
    res_ready = 1; tick(); res_ready = 0;
  endtask

  task automatic txn(input bit r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] exp, input bit exp_id);
    int ta, tr;
    send(r, a, b, ta);
    wait_res(tr);
    chk("latency", tr - ta, W);
    chk("flags_lit", {res_less, res_eq, res_greater}, exp);
    chk("id_lit", res_id, exp_id);
    @(posedge clk); #1;
    consume();
  endtask

  initial begin
    int ta, tr, n, acc_id[4], acc_t[4];
    repeat (3) tick();
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {req0_ready, req1_ready, res_valid, res_less, res_eq, res_greater}, 0);
    end
    tick();
    txn(0, 8'h80, 8'h7F, 3'b001, 0);
    txn(1, 8'hA5, 8'hA5, 3'b010, 1);
    // both requesters streaming: arbitration must alternate starting from requester 0
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1; req1_a = 8'h10; req1_b = 8'h10;
    res_ready = 1; n = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      @(negedge clk);
      if (req0_ready) begin acc_id[n] = 0; acc_t[n] = cyc; n++; end
      else if (req1_ready) begin acc_id[n] = 1; acc_t[n] = cyc; n++; end
      @(posedge clk); #1;
      if (n == 4) begin req0_valid = 0; req1_valid = 0; end
    end
    chk("stream_count", n, 4);
    for (int i = 0; i < n; i++) chk("stream_order", acc_id[i], i % 2);
    for (int i = 1; i < n; i++) chk("stream_gap", acc_t[i] - acc_t[i-1], W + 2);
    repeat (W + 4) tick();
    res_ready = 0;
    txn(0, 8'h00, 8'hFF, 3'b100, 0);
    // stall the consumer while the other requester waits
    send(1, 8'h40, 8'h20, ta);
    req0_valid = 1; req0_a = 8'h05; req0_b = 8'h06;
    wait_res(tr);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_readys", {req0_ready, req1_ready}, 0);
      chk("stall_hold", {res_valid, res_id, res_less, res_eq, res_greater}, 5'b11001);
    end
    @(posedge clk); #1;
    consume();
    @(negedge clk);
    chk("after_stall_grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 0;
    wait_res(tr);
    chk("after_stall_less", res_less, 1);
    @(posedge clk); #1;
    consume();
    // asynchronous reset in the middle of a compare
    send(0, 8'h11, 8'h22, ta);
    tick(); tick();
    req1_valid = 1;
    #2 rst = 0;
    #1;
    chk("async_rst", {res_valid, req0_ready, req1_ready, res_less, res_eq, res_greater}, 0);
    @(posedge clk); #1;
    rst = 1; req1_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("no_stale", res_valid, 0);
    end
    tick();
    req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h00;
    txn(0, 8'h3C, 8'h3D, 3'b100, 0);
    txn(1, 8'hFF, 8'h00, 3'b001, 1);
    // randomized traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      bit a0, a1;
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0 || !req0_valid) begin
        req0_valid = $urandom_range(0, 3) != 0;
        req0_a = W'($urandom);
        req0_b = $urandom_range(0, 3) == 0 ? req0_a : W'($urandom);
      end
      if (a1 || !req1_valid) begin
        req1_valid = $urandom_range(0, 3) != 0;
        req1_a = W'($urandom);
        req1_b = $urandom_range(0, 3) == 0 ? req1_a : W'($urandom);
      end
      res_ready = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 599) != 0;
    end
    rst = 1;
    repeat (2) tick();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
